// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC scheduler: FP format, FSM states, helpers.
package neuron_pkg;

  localparam int FP_W     = 12;
  localparam int SIGN_BIT = 11;
  localparam int EXP_W    = 5;
  localparam int MANT_W   = 6;

  localparam logic [FP_W-1:0] FP_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_RES,
    WRITE,
    FIN
  } state_t;

  function automatic logic fp_is_neg(input logic [FP_W-1:0] value);
    return value[SIGN_BIT];
  endfunction

endpackage

// File: rtl/neuron_addr_gen.sv
// Input/neuron counters and running weight address (j*N+i without a multiplier).
module neuron_addr_gen #(
  parameter int NI_W    = 4,
  parameter int NN_W    = 4,
  parameter int WADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               nextNeuron,
  input  logic [NI_W-1:0]    numInputs,
  input  logic [NN_W-1:0]    numNeurons,
  output logic [NI_W-1:0]    inIdx,
  output logic [NN_W-1:0]    neuronIdx,
  output logic [WADDR_W-1:0] wAddr,
  output logic               firstPair,
  output logic               lastPair,
  output logic               lastNeuron
);

  localparam logic [NI_W-1:0]    ONE_I = 1;
  localparam logic [NN_W-1:0]    ONE_N = 1;
  localparam logic [WADDR_W-1:0] ONE_W = 1;

  logic [NI_W-1:0] nReg;
  logic [NN_W-1:0] mReg;

  // Latch job size at accept, then advance i per accepted pair and j per written neuron
  always_ff @(posedge clk) begin
    if (rst) begin
      nReg      <= '0;
      mReg      <= '0;
      inIdx     <= '0;
      neuronIdx <= '0;
      wAddr     <= '0;
    end else if (load) begin
      nReg      <= numInputs;
      mReg      <= numNeurons;
      inIdx     <= '0;
      neuronIdx <= '0;
      wAddr     <= '0;
    end else begin
      // weights are laid out neuron-major, so wAddr simply advances on every pair
      if (step) begin
        wAddr <= wAddr + ONE_W;
        if (!lastPair) begin
          inIdx <= inIdx + ONE_I;
        end
      end
      if (nextNeuron) begin
        inIdx     <= '0;
        neuronIdx <= neuronIdx + ONE_N;
      end
    end
  end

  // Position flags relative to the latched job size
  always_comb begin
    firstPair  = (inIdx == '0);
    lastPair   = (inIdx == nReg - ONE_I);
    lastNeuron = (neuronIdx == mReg - ONE_N);
  end

endmodule

// File: rtl/neuron_mac_scheduler.sv
// Layer controller time-sharing one external FP MAC across all neurons of a layer.
// Optional feature: define RELU_EN to clamp negative neuron results to zero.
module neuron_mac_scheduler
  import neuron_pkg::*;
#(
  parameter int NI_W    = 4,
  parameter int NN_W    = 4,
  parameter int WADDR_W = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [NI_W-1:0]    NumInputs,
  input  logic [NN_W-1:0]    NumNeurons,
  output logic               Busy,
  output logic               Done,
  output logic [NI_W-1:0]    InAddr,
  input  logic [FP_W-1:0]    InData,
  output logic [WADDR_W-1:0] WAddr,
  input  logic [FP_W-1:0]    WData,
  output logic               MacValid,
  input  logic               MacReady,
  output logic [FP_W-1:0]    MacA,
  output logic [FP_W-1:0]    MacB,
  output logic               MacClear,
  output logic               MacLast,
  input  logic               MacResValid,
  input  logic [FP_W-1:0]    MacResult,
  output logic               OutWe,
  output logic [NN_W-1:0]    OutAddr,
  output logic [FP_W-1:0]    OutData
);

  state_t state, nextState;

  logic [NI_W-1:0]    inIdx;
  logic [NN_W-1:0]    neuronIdx;
  logic [WADDR_W-1:0] wAddr;
  logic               firstPair, lastPair, lastNeuron;
  logic               load, step, nextNeuron;
  logic               held;
  logic [FP_W-1:0]    opA, opB, resReg, outVal;

  neuron_addr_gen #(
    .NI_W    (NI_W),
    .NN_W    (NN_W),
    .WADDR_W (WADDR_W)
  ) addrGen (
    .clk        (Clock),
    .rst        (Reset),
    .load       (load),
    .step       (step),
    .nextNeuron (nextNeuron),
    .numInputs  (NumInputs),
    .numNeurons (NumNeurons),
    .inIdx      (inIdx),
    .neuronIdx  (neuronIdx),
    .wAddr      (wAddr),
    .firstPair  (firstPair),
    .lastPair   (lastPair),
    .lastNeuron (lastNeuron)
  );

  // State register, operand hold registers and result capture
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      held   <= 1'b0;
      opA    <= '0;
      opB    <= '0;
      resReg <= '0;
    end else begin
      state <= nextState;
      // Read data arrives in the first ISSUE cycle and is passed straight through;
      // it is captured then and replayed while the MAC stalls, so the pair stays stable.
      held  <= (state == ISSUE) && !MacReady;
      if (state == ISSUE) begin
        opA <= MacA;
        opB <= MacB;
      end
      if ((state == WAIT_RES) && MacResValid) begin
        resReg <= MacResult;
      end
    end
  end

  // Next-state logic and counter controls
  always_comb begin
    nextState  = state;
    load       = 1'b0;
    step       = 1'b0;
    nextNeuron = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load      = 1'b1;
          nextState = ((NumInputs != '0) && (NumNeurons != '0)) ? FETCH : FIN;
        end
      end
      FETCH:    nextState = ISSUE;
      ISSUE: begin
        if (MacReady) begin
          step      = 1'b1;
          nextState = lastPair ? WAIT_RES : FETCH;
        end
      end
      WAIT_RES: begin
        if (MacResValid) begin
          nextState = WRITE;
        end
      end
      WRITE: begin
        nextNeuron = !lastNeuron;
        nextState  = lastNeuron ? FIN : FETCH;
      end
      FIN:      nextState = IDLE;
      default:  nextState = IDLE;
    endcase
  end

  // Neuron output value, optionally rectified
  always_comb begin
`ifdef RELU_EN
    outVal = fp_is_neg(resReg) ? FP_ZERO : resReg;
`else
    outVal = resReg;
`endif
  end

  // State-decoded outputs
  always_comb begin
    Busy     = (state == FETCH) || (state == ISSUE) || (state == WAIT_RES) || (state == WRITE);
    Done     = (state == FIN);
    InAddr   = inIdx;
    WAddr    = wAddr;
    MacValid = (state == ISSUE);
    MacClear = (state == ISSUE) && firstPair;
    MacLast  = (state == ISSUE) && lastPair;
    MacA     = '0;
    MacB     = '0;
    if (state == ISSUE) begin
      MacA = held ? opA : InData;
      MacB = held ? opB : WData;
    end
    OutWe    = (state == WRITE);
    OutAddr  = (state == WRITE) ? neuronIdx : '0;
    OutData  = (state == WRITE) ? outVal : FP_ZERO;
  end

endmodule

// File: tb/tb_neuron_mac_scheduler.sv
// Directed self-checking bench for neuron_mac_scheduler with memory and MAC models.
module tb_neuron_mac_scheduler;

  localparam int NI_W    = 4;
  localparam int NN_W    = 4;
  localparam int WADDR_W = 8;

  logic               Clock = 1'b0;
  logic               Reset = 1'b1;
  logic               Start = 1'b0;
  logic [NI_W-1:0]    NumInputs = '0;
  logic [NN_W-1:0]    NumNeurons = '0;
  logic               Busy, Done;
  logic [NI_W-1:0]    InAddr;
  logic [11:0]        InData = '0;
  logic [WADDR_W-1:0] WAddr;
  logic [11:0]        WData = '0;
  logic               MacValid;
  logic               MacReady = 1'b1;
  logic [11:0]        MacA, MacB;
  logic               MacClear, MacLast;
  logic               MacResValid = 1'b0;
  logic [11:0]        MacResult = '0;
  logic               OutWe;
  logic [NN_W-1:0]    OutAddr;
  logic [11:0]        OutData;

  neuron_mac_scheduler #(
    .NI_W    (NI_W),
    .NN_W    (NN_W),
    .WADDR_W (WADDR_W)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .NumInputs   (NumInputs),
    .NumNeurons  (NumNeurons),
    .Busy        (Busy),
    .Done        (Done),
    .InAddr      (InAddr),
    .InData      (InData),
    .WAddr       (WAddr),
    .WData       (WData),
    .MacValid    (MacValid),
    .MacReady    (MacReady),
    .MacA        (MacA),
    .MacB        (MacB),
    .MacClear    (MacClear),
    .MacLast     (MacLast),
    .MacResValid (MacResValid),
    .MacResult   (MacResult),
    .OutWe       (OutWe),
    .OutAddr     (OutAddr),
    .OutData     (OutData)
  );

  always #5 Clock = ~Clock;

  int compared   = 0;
  int mismatched = 0;

  logic [11:0] inMem [16];
  logic [11:0] wMem  [256];

  logic [NI_W-1:0]    snapIn = '0;
  logic [WADDR_W-1:0] snapW  = '0;
  int cycleNo   = 0;
  int stallPair = -1;
  int stallLeft = 0;
  int injectAt  = -1;
  bit pendRes   = 0;
  int lastsSeen = 0;
  bit useNeg    = 0;
  int jobN      = 1;
  logic [11:0] negResult = 12'b1_01100_111000;

  logic [11:0]        pA [256];
  logic [11:0]        pB [256];
  logic               pClr [256];
  logic               pLst [256];
  logic [WADDR_W-1:0] pW [256];
  logic [NN_W-1:0]    wrAddr [32];
  logic [11:0]        wrData [32];
  int                 wrCyc [32];
  int pairCnt, wrCnt, doneCnt, doneCyc, busyCnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] resFor(input int n);
    if (useNeg && n == 0) return negResult;
    return 12'h050 + 12'(n);
  endfunction

  function automatic logic [11:0] expOut(input logic [11:0] v);
`ifdef RELU_EN
    return v[11] ? 12'h000 : v;
`else
    return v;
`endif
  endfunction

  // One clock: update memory/MAC model inputs, then log the settled outputs
  task automatic cyc();
    int i;
    @(posedge Clock);
    #1;
    cycleNo++;
    InData      = inMem[snapIn];
    WData       = wMem[snapW];
    MacResValid = 1'b0;
    MacResult   = '0;
    if (pendRes) begin
      MacResValid = 1'b1;
      MacResult   = resFor(lastsSeen);
      lastsSeen++;
      pendRes = 0;
    end
    if (cycleNo == injectAt) begin
      MacResValid = 1'b1;
      MacResult   = 12'h7FF;
    end
    if (stallPair >= 0 && MacValid && pairCnt == stallPair) begin
      stallLeft = 5;
      stallPair = -1;
    end
    MacReady = (stallLeft == 0);
    if (stallLeft > 0) stallLeft--;
    #2;
    if (MacValid && !MacReady) begin
      i = pairCnt % jobN;
      check("stall_valid", MacValid, 1);
      check("stall_A", MacA, inMem[i]);
      check("stall_B", MacB, wMem[pairCnt]);
    end
    if (MacValid && MacReady && pairCnt < 256) begin
      pA[pairCnt]   = MacA;
      pB[pairCnt]   = MacB;
      pClr[pairCnt] = MacClear;
      pLst[pairCnt] = MacLast;
      pW[pairCnt]   = WAddr;
      pairCnt++;
      if (MacLast) pendRes = 1;
    end
    if (OutWe && wrCnt < 32) begin
      wrAddr[wrCnt] = OutAddr;
      wrData[wrCnt] = OutData;
      wrCyc[wrCnt]  = cycleNo;
      wrCnt++;
    end
    if (Done) begin
      doneCnt++;
      doneCyc = cycleNo;
    end
    if (Busy) busyCnt++;
    snapIn = InAddr;
    snapW  = WAddr;
  endtask

  task automatic clearLogs();
    pairCnt = 0; wrCnt = 0; doneCnt = 0; doneCyc = -1; busyCnt = 0; lastsSeen = 0;
  endtask

  task automatic runJob(input string tag, input int n, input int m, input int stallAt, input bit inject);
    int k0, expPairs, expWrites, stallC, lim;
    clearLogs();
    jobN       = (n == 0) ? 1 : n;
    stallPair  = stallAt;
    NumInputs  = NI_W'(n);
    NumNeurons = NN_W'(m);
    Start      = 1'b1;
    k0         = cycleNo + 1;
    if (inject) injectAt = k0;
    cyc();
    Start = 1'b0;
    check({tag, "_busy_after_accept"}, Busy, (n != 0 && m != 0));
    lim = 0;
    while (doneCnt == 0 && lim < 3000) begin
      if (inject && cycleNo == k0 + 3) begin
        Start = 1'b1; NumInputs = 4'd5; NumNeurons = 4'd1;
      end else begin
        Start = 1'b0;
      end
      cyc();
      lim++;
    end
    Start = 1'b0;
    injectAt = -1;
    check({tag, "_done_seen"}, doneCnt, 1);
    cyc();
    cyc();
    check({tag, "_done_single"}, doneCnt, 1);
    check({tag, "_idle_busy"}, Busy, 0);
    expPairs  = (n == 0 || m == 0) ? 0 : n * m;
    expWrites = (expPairs == 0) ? 0 : m;
    stallC    = (stallAt >= 0) ? 5 : 0;
    check({tag, "_pairs"}, pairCnt, expPairs);
    check({tag, "_writes"}, wrCnt, expWrites);
    check({tag, "_done_cycle"}, doneCyc, k0 + ((expPairs == 0) ? 0 : m * (2 * n + 2) + stallC));
    check({tag, "_busy_cycles"}, busyCnt, doneCyc - k0);
    for (int p = 0; p < pairCnt && p < expPairs; p++) begin
      check({tag, "_pairA"}, pA[p], inMem[p % n]);
      check({tag, "_pairB"}, pB[p], wMem[p]);
      check({tag, "_pairClear"}, pClr[p], (p % n) == 0);
      check({tag, "_pairLast"}, pLst[p], (p % n) == n - 1);
      check({tag, "_pairWAddr"}, pW[p], p);
    end
    for (int w = 0; w < wrCnt && w < expWrites; w++) begin
      check({tag, "_outAddr"}, wrAddr[w], w);
      check({tag, "_outData"}, wrData[w], expOut(resFor(w)));
    end
    if (expWrites > 0 && wrCnt > 0) begin
      check({tag, "_done_after_write"}, doneCyc, wrCyc[wrCnt-1] + 1);
    end
  endtask

  initial begin
    int k0;
    for (int i = 0; i < 16; i++) inMem[i] = 12'h100 + 12'(i);
    for (int k = 0; k < 256; k++) wMem[k] = 12'h400 + 12'(k);

    // reset state
    Reset = 1'b1;
    cyc();
    cyc();
    check("reset_ctl", {26'd0, Busy, Done, MacValid, MacClear, MacLast, OutWe}, 0);
    check("reset_addr", {InAddr, WAddr}, 0);
    check("reset_mac", {MacA, MacB}, 0);
    check("reset_out", {OutAddr, OutData}, 0);
    Reset = 1'b0;
    cyc();

    // basic job, stalled job, empty jobs
    runJob("t1", 3, 2, -1, 0);
    runJob("t2_stall", 3, 2, 1, 0);
    runJob("t3_n0", 0, 4, -1, 0);
    runJob("t3_m0", 5, 0, -1, 0);

    // reset during ISSUE of neuron 1
    clearLogs();
    jobN = 3; NumInputs = 4'd3; NumNeurons = 4'd2; Start = 1'b1;
    k0 = cycleNo + 1;
    cyc();
    Start = 1'b0;
    while (cycleNo < k0 + 9) cyc();
    check("t4_issue_valid", MacValid, 1);
    check("t4_issue_clear", MacClear, 1);
    check("t4_issue_waddr", WAddr, 3);
    Reset = 1'b1;
    cyc();
    check("t4_rst_ctl", {26'd0, Busy, Done, MacValid, MacClear, MacLast, OutWe}, 0);
    check("t4_rst_addr", {InAddr, WAddr}, 0);
    check("t4_rst_mac", {MacA, MacB}, 0);
    check("t4_rst_out", {OutAddr, OutData}, 0);
    Reset = 1'b0;
    pendRes = 0; stallLeft = 0; wrCnt = 0; doneCnt = 0; busyCnt = 0;
    cyc(); cyc(); cyc();
    check("t4_no_write", wrCnt, 0);
    check("t4_no_done", doneCnt, 0);
    check("t4_no_busy", busyCnt, 0);
    runJob("t4_rerun", 3, 2, -1, 0);

    // negative result, ignored Start/strobe, size boundaries
    useNeg = 1;
    runJob("t5_neg", 2, 1, -1, 0);
    useNeg = 0;
    runJob("t6_ignore", 2, 3, -1, 1);
    runJob("t7_n1m1", 1, 1, -1, 0);
    runJob("t8_max", 15, 15, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
